symfir_coef_load: RTL
=====================

# symfir_coef_load

Parametrised, fully parallel odd-length symmetric FIR filter for the sample-rate datapath, driven by sys_clk and qualified by sam_clk_en. It is the successor to the fixed 101-tap matched filter. Length and width are generic, the adder tree is generated automatically, and coefficients load at runtime through a double-buffered bank with atomic commit. It also provides an output-valid indication and optional saturating arithmetic.

## Interface
- WIDTH, 18: sample, coefficient and tree word width (signed).
- LENGTH, 101: filter length; must be odd and ≥3. NU=(LENGTH+1)/2 unique taps.
- AW, 7: coefficient address width; 2^AW ≥ NU.

Ports:
- sys_clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high; clock sys_clk.
- sam_clk_en  in  1  sample strobe; all datapath registers advance only when high.
- x_in  in  WIDTH  input sample, 1sWIDTH-1 format.
- coef_wr_en  in  1  write coef_data into shadow bank at coef_addr.
- coef_addr  in  AW  shadow index 0..NU-1; index NU-1 is the centre tap.
- coef_data  in  WIDTH  coefficient, 0sWIDTH format.
- coef_commit  in  1  request shadow→active copy.
- coef_pending  out  1  commit requested, not yet applied.
- y  out  WIDTH  filter output, 1sWIDTH-1 format.
- y_valid  out  1  one-cycle pulse when y updates with a fully-primed pipeline.
- sat_seen  out  1  sticky saturation indicator.

## Operation
- **Input stage.** x[0] ← {x_in[MSB], x_in[MSB:1]}, an arithmetic shift that gives 2s(WIDTH-2). The delay line x[1..LENGTH-1] shifts on sam_clk_en.
- **Pre-add.** p[i] = x[i] + x[LENGTH-1-i] for i < NU-1. p[NU-1] = x[NU-1] (centre tap, not paired).
- **Multiply.** m[i] = active[i] * p[i], 2*WIDTH bits. Keep bits [2*WIDTH-2 : WIDTH-1] and truncate the rest (no rounding).
- **First tree level.** Register sums of m pairs.
- **Adder tree.** Each level registers pairwise sums. When a level has an odd count, its last element passes through unchanged. Levels repeat until one word remains. The number of levels is computed from NU with generate; no per-length hand edits.
- **Output.** y ← final sum.
- **Coefficients.**
  - A write with coef_addr ≥ NU is ignored.
  - coef_commit sets coef_pending.
  - On the next sam_clk_en cycle with coef_pending=1, all NU active words ← shadow in that one cycle, and coef_pending clears.
  - If coef_commit and sam_clk_en are asserted in the same cycle, the copy is deferred to the next sam_clk_en.
  - A write in the same cycle as the copy: the write lands in shadow only; active receives the pre-write shadow.
- **y_valid.** A counter of sam_clk_en cycles since reset saturates at LAT. y_valid = sam_clk_en & (counter == LAT), registered alongside y.
- **Reset.** Clears:
  - x, the pipeline, y, y_valid and sat_seen;
  - both coefficient banks to 0;
  - coef_pending;
  - the valid counter.

  Reset asserted mid-operation discards in-flight samples and any pending commit. Reset takes priority over every other input.

## Timing
- LAT = 3 + ceil(log2(NU)) sam_clk_en cycles; LAT = 9 for LENGTH=101.
- Latency reference: the enable that captures x_in counts as enable 1. Its contribution through tap k (k < NU) appears in y after enable LAT+k. Its contribution through mirror tap LENGTH-1-k appears after enable LAT+LENGTH-1-k.
- Between sam_clk_en pulses:
  - all datapath registers and y hold;
  - y_valid is 0;
  - coefficient writes still take effect (shadow only).
- The multiply is combinational between the pre-add register and the first tree register.
- The first y_valid pulse is at enable LAT+1 after reset.

## Configuration
- SYMFIR_SAT_EN defined: every pre-add and tree addition saturates to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. sat_seen sets on any clamp and clears only on reset.
- SYMFIR_SAT_EN undefined: additions wrap modulo 2^WIDTH, and sat_seen is tied to 0.

## Test plan
- **Impulse.** Stimulus: LENGTH=101; load active[k]=400 for all k and commit. Apply one x_in=65536 then zeros, sam_clk_en every 4th cycle. Required: y=100 after enables 9..58 and 59..109, y=0 elsewhere. The centre tap gives exactly one y=100, after enable 59.
- **Atomic commit.** Stimulus: active=0. Write shadow[0]=400, then assert coef_commit together with sam_clk_en; feed a constant x_in=65536. Required: coef_pending stays high until the following enable, and y changes only LAT enables after the copy.
- **Ignored write.** Stimulus: a write to coef_addr=NU, i.e. 51. Required: no bank changes, and impulse response is unchanged.
- **y_valid.** Stimulus: reset, then continuous sam_clk_en. Required: y_valid=0 for enables 1..9, then 1 from enable 10. A reset pulse mid-stream returns y=0 and y_valid=0, and the count restarts.
- **Saturation.** Stimulus: all coefficients 131071, x_in=131071 constant. Required with SYMFIR_SAT_EN: y=131071 in steady state and sat_seen=1. Required without it: y equals the modulo-2^18 wrapped sum and sat_seen=0.
- **Enable gating.** Stimulus: hold sam_clk_en=0 for 50 cycles mid-stream. Required: y, the pipeline and the delay line are unchanged, and no y_valid pulses occur.

Source files
------------

// File: rtl/symfir_coef_load_if.sv
// rtl/symfir_coef_load_if.sv - coefficient load bus for symfir_coef_load
//
// Carries runtime coefficient writes into the shadow bank, the commit request
// and the pending flag. The master drives writes and commits. The slave, which
// is the filter, reports coef_pending.
//   coef_wr_en    write coef_data to shadow[coef_addr]
//   coef_addr     shadow index, AW bits
//   coef_data     coefficient word, WIDTH bits signed
//   coef_commit   request a shadow-to-active copy
//   coef_pending  commit requested, not yet applied
interface symfir_coef_load_if #(
    parameter int WIDTH = 18,
    parameter int AW    = 7
);
    logic                    coef_wr_en;
    logic [AW-1:0]           coef_addr;
    logic signed [WIDTH-1:0] coef_data;
    logic                    coef_commit;
    logic                    coef_pending;

    modport master (
        output coef_wr_en, coef_addr, coef_data, coef_commit,
        input  coef_pending
    );

    modport slave (
        input  coef_wr_en, coef_addr, coef_data, coef_commit,
        output coef_pending
    );
endinterface

// File: rtl/symfir_coef_load.sv
// rtl/symfir_coef_load.sv - parametrised odd-length symmetric FIR with double-buffered coefficients
//
// Ports:
//   sys_clk, reset   clock; synchronous active-high reset
//   sam_clk_en       sample strobe; every datapath register advances only when high
//   x_in             input sample, 1sWIDTH-1
//   coef_bus         coefficient load interface (slave modport)
//   y                filter output, 1sWIDTH-1
//   y_valid          one-cycle pulse with each y update once the pipeline is primed
//   sat_seen         sticky clamp indicator
// Optional feature: define SYMFIR_SAT_EN to make every pre-add and tree
// addition saturate. Without it, additions wrap and sat_seen stays 0.
module symfir_coef_load #(
    parameter int WIDTH  = 18,
    parameter int LENGTH = 101,
    parameter int AW     = 7
) (
    input  logic                    sys_clk,
    input  logic                    reset,
    input  logic                    sam_clk_en,
    input  logic signed [WIDTH-1:0] x_in,
    symfir_coef_load_if.slave       coef_bus,
    output logic signed [WIDTH-1:0] y,
    output logic                    y_valid,
    output logic                    sat_seen
);
    localparam int NU   = (LENGTH + 1) / 2;
    localparam int NLEV = $clog2(NU);
    localparam int LAT  = 3 + NLEV;
    localparam int CW   = $clog2(LAT + 1);
    localparam int PW   = 2 * WIDTH;

    // Number of words left after l pairwise tree levels.
    function automatic int level_cnt(input int l);
        return (NU + (1 << l) - 1) >> l;
    endfunction

    // Returns {clamped, sum}.
    function automatic logic [WIDTH:0] add_w(input logic signed [WIDTH-1:0] a, b);
`ifdef SYMFIR_SAT_EN
        logic signed [WIDTH:0] ext;
        ext = (WIDTH+1)'(a) + (WIDTH+1)'(b);
        if (ext[WIDTH] != ext[WIDTH-1])
            return {1'b1, ext[WIDTH], {(WIDTH-1){~ext[WIDTH]}}};
        return {1'b0, ext[WIDTH-1:0]};
`else
        return {1'b0, a + b};
`endif
    endfunction

    // Full product, then keep bits [2W-2:W-1], which is a plain truncation.
    function automatic logic signed [WIDTH-1:0] mul_trunc(input logic signed [WIDTH-1:0] c, d);
        return WIDTH'((PW'(c) * PW'(d)) >>> (WIDTH - 1));
    endfunction

    // Coefficient banks
    logic signed [WIDTH-1:0] shadow [NU];
    logic signed [WIDTH-1:0] active [NU];
    logic                    pending;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            pending <= 1'b0;
            for (int k = 0; k < NU; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
        end else begin
            // The copy reads the shadow bank as it was before this cycle's write.
            if (sam_clk_en && pending) begin
                for (int k = 0; k < NU; k++)
                    active[k] <= shadow[k];
            end
            // The address is decoded against 0..NU-1 only, so writes beyond NU-1 match nothing.
            for (int k = 0; k < NU; k++) begin
                if (coef_bus.coef_wr_en && coef_bus.coef_addr == AW'(k))
                    shadow[k] <= coef_bus.coef_data;
            end
            // A commit that arrives with an enable is applied on the next enable.
            if (coef_bus.coef_commit)
                pending <= 1'b1;
            else if (sam_clk_en)
                pending <= 1'b0;
        end
    end

    assign coef_bus.coef_pending = pending;

    // Delay line, pre-add and multiply
    logic signed [WIDTH-1:0] x     [LENGTH];
    logic signed [WIDTH-1:0] p     [NU];
    logic signed [WIDTH-1:0] p_nxt [NU];
    logic signed [WIDTH-1:0] m     [NU];
    logic [WIDTH:0]          pre_r;
    logic                    pre_sat;

    always_comb begin
        pre_sat = 1'b0;
        pre_r   = '0;
        for (int i = 0; i < NU - 1; i++) begin
            pre_r    = add_w(x[i], x[LENGTH-1-i]);
            p_nxt[i] = pre_r[WIDTH-1:0];
            pre_sat  = pre_sat | pre_r[WIDTH];
        end
        p_nxt[NU-1] = x[NU-1];
    end

    always_comb begin
        for (int i = 0; i < NU; i++)
            m[i] = mul_trunc(active[i], p[i]);
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            for (int k = 0; k < LENGTH; k++)
                x[k] <= '0;
            for (int i = 0; i < NU; i++)
                p[i] <= '0;
        end else if (sam_clk_en) begin
            // A one-bit arithmetic shift gives the pre-add headroom, so x is 2s(WIDTH-2).
            x[0] <= x_in >>> 1;
            for (int k = 1; k < LENGTH; k++)
                x[k] <= x[k-1];
            for (int i = 0; i < NU; i++)
                p[i] <= p_nxt[i];
        end
    end

    // Registered adder tree. Level 1 sums the multiplier outputs.
    logic [NLEV-1:0] lvl_clamp;

    generate
        for (genvar l = 1; l <= NLEV; l++) begin : g_lvl
            localparam int NI = level_cnt(l - 1);
            localparam int NO = level_cnt(l);
            logic signed [WIDTH-1:0] din [NI];
            logic signed [WIDTH-1:0] nxt [NO];
            logic signed [WIDTH-1:0] s   [NO];
            logic [WIDTH:0]          r;
            logic                    clamp;

            for (genvar j = 0; j < NI; j++) begin : g_in
                if (l == 1) begin : g_m
                    assign din[j] = m[j];
                end else begin : g_prev
                    assign din[j] = g_lvl[l-1].s[j];
                end
            end

            always_comb begin
                clamp = 1'b0;
                r     = '0;
                for (int j = 0; j < NO; j++) begin
                    if (2 * j + 1 < NI) begin
                        r      = add_w(din[2*j], din[2*j+1]);
                        nxt[j] = r[WIDTH-1:0];
                        clamp  = clamp | r[WIDTH];
                    end else begin
                        // The odd element at the end of the level passes through unchanged.
                        nxt[j] = din[2*j];
                    end
                end
            end

            always_ff @(posedge sys_clk) begin
                if (reset) begin
                    for (int j = 0; j < NO; j++)
                        s[j] <= '0;
                end else if (sam_clk_en) begin
                    for (int j = 0; j < NO; j++)
                        s[j] <= nxt[j];
                end
            end

            assign lvl_clamp[l-1] = clamp;
        end
    endgenerate

    // Output, valid counter and sticky clamp flag
    logic [CW-1:0] vcnt;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            y        <= '0;
            y_valid  <= 1'b0;
            vcnt     <= '0;
            sat_seen <= 1'b0;
        end else begin
            y_valid <= sam_clk_en && (vcnt == CW'(LAT));
            if (sam_clk_en) begin
                y <= g_lvl[NLEV].s[0];
                if (vcnt != CW'(LAT))
                    vcnt <= vcnt + CW'(1);
                // With wrapping additions the clamp flags are constant 0, so this register stays 0.
                sat_seen <= sat_seen | pre_sat | (|lvl_clamp);
            end
        end
    end
endmodule
